// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - BCH(264,192) t=8 constants, generator polynomial and FSM states
package puf_pkg;
  localparam int DATA_BITS = 192;
  localparam int N         = 264;
  localparam int PAR_BITS  = N - DATA_BITS;
  localparam int BCH_M     = 9;
  localparam int BCH_T     = 8;
  localparam int GF_ORDER  = (1 << BCH_M) - 1;
  // x^9 = x^4 + 1 in GF(2^9)
  localparam logic [BCH_M-1:0] PRIM_LOW = 9'h011;

  function automatic logic [BCH_M-1:0] gf_mul(input logic [BCH_M-1:0] a, input logic [BCH_M-1:0] b);
    logic [BCH_M-1:0] acc;
    logic [BCH_M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < BCH_M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[BCH_M-1] ? ((sh << 1) ^ PRIM_LOW) : (sh << 1);
    end
    return acc;
  endfunction

  // g(x) = product of (x + alpha^e) over the union of the cyclotomic cosets of 1,3,...,2t-1
  function automatic logic [PAR_BITS:0] bch_gen_poly();
    logic [GF_ORDER-1:0]            roots;
    logic [(PAR_BITS+1)*BCH_M-1:0] g;
    logic [BCH_M-1:0]              a_e;
    logic [PAR_BITS:0]             res;
    int                            j;
    int                            deg;
    roots = '0;
    for (int i = 1; i < 2 * BCH_T; i = i + 2) begin
      j = i;
      for (int k = 0; k < BCH_M; k++) begin
        roots[j] = 1'b1;
        j = (j * 2) % GF_ORDER;
      end
    end
    g = '0;
    g[BCH_M-1:0] = BCH_M'(1);
    deg = 0;
    a_e = BCH_M'(1);
    for (int e = 0; e < GF_ORDER; e++) begin
      if (roots[e]) begin
        deg = deg + 1;
        for (int k = deg; k > 0; k--)
          g[k*BCH_M +: BCH_M] = g[(k-1)*BCH_M +: BCH_M] ^ gf_mul(a_e, g[k*BCH_M +: BCH_M]);
        g[BCH_M-1:0] = gf_mul(a_e, g[BCH_M-1:0]);
      end
      a_e = gf_mul(a_e, BCH_M'(2));
    end
    for (int k = 0; k <= PAR_BITS; k++) res[k] = g[k*BCH_M];
    return res;
  endfunction

  localparam logic [PAR_BITS:0] BCH_GEN_POLY = bch_gen_poly();

  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;
endpackage

// File: rtl/puf_helper_gen_if.sv
// rtl/puf_helper_gen_if.sv - request/result bundle of the helper-data generator
interface puf_helper_gen_if;
  import puf_pkg::*;

  logic                 start;
  logic [N-1:0]         response;
  logic [DATA_BITS-1:0] secret;
  logic [N-1:0]         helper;
  logic [N-1:0]         codeword;
  logic                 busy;
  logic                 ready;

  modport master (output start, response, secret, input helper, codeword, busy, ready);
  modport slave  (input start, response, secret, output helper, codeword, busy, ready);
endinterface

// File: rtl/bch_lfsr_enc.sv
// rtl/bch_lfsr_enc.sv - bit-serial systematic BCH parity generator (MSB-first division)
module bch_lfsr_enc #(
  parameter int                PAR_BITS = 72,
  parameter logic [PAR_BITS:0] GEN_POLY = {1'b1, {PAR_BITS{1'b0}}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                shift_en,
  input  logic                data_bit,
  output logic [PAR_BITS-1:0] parity
);
  logic fb;

  assign fb = data_bit ^ parity[PAR_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= '0;
    end else if (clear) begin
      parity <= '0;
    end else if (shift_en) begin
      parity <= {parity[PAR_BITS-2:0], 1'b0} ^ (fb ? GEN_POLY[PAR_BITS-1:0] : '0);
    end
  end
endmodule

// File: rtl/puf_helper_gen.sv
// rtl/puf_helper_gen.sv - enrollment: BCH-encode the secret and mask it with the PUF response
module puf_helper_gen
  import puf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  puf_helper_gen_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_BITS);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS-1:0] msg_sr;
  logic [DATA_BITS-1:0] secret_q;
  logic [N-1:0]         response_q;
  logic [N-1:0]         helper_q;
  logic [N-1:0]         codeword_q;
  logic                 busy_q;
  logic                 ready_q;
  logic                 load;
  logic                 enc_en;
  logic                 write_out;
  logic [PAR_BITS-1:0]  parity;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    enc_en    = 1'b0;
    write_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ENC;
        end
      end
      ENC: begin
        enc_en = 1'b1;
        if (cnt == CNT_W'(DATA_BITS - 1)) state_nxt = OUT;
      end
      OUT: begin
        write_out = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // secret_q is kept apart from msg_sr because the shift register is consumed by encoding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      msg_sr     <= '0;
      secret_q   <= '0;
      response_q <= '0;
      helper_q   <= '0;
      codeword_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      if (load) begin
        msg_sr     <= bus.secret;
        secret_q   <= bus.secret;
        response_q <= bus.response;
        cnt        <= '0;
        busy_q     <= 1'b1;
        ready_q    <= 1'b0;
      end
      if (enc_en) begin
        msg_sr <= msg_sr << 1;
        cnt    <= cnt + CNT_W'(1);
      end
      if (write_out) begin
        codeword_q <= {secret_q, parity};
        helper_q   <= {secret_q, parity} ^ response_q;
        busy_q     <= 1'b0;
        ready_q    <= 1'b1;
      end
    end
  end

  bch_lfsr_enc #(
    .PAR_BITS (PAR_BITS),
    .GEN_POLY (BCH_GEN_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (load),
    .shift_en (enc_en),
    .data_bit (msg_sr[DATA_BITS-1]),
    .parity   (parity)
  );

  assign bus.helper   = helper_q;
  assign bus.codeword = codeword_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
endmodule

// File: tb/tb_puf_helper_gen.sv
// tb/tb_puf_helper_gen.sv - randomized self-checking bench for puf_helper_gen
module tb_puf_helper_gen;
  import puf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  puf_helper_gen_if bus();
  puf_helper_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic         m_busy, m_ready;
  logic [N-1:0] m_helper, m_code, m_next_code, m_next_helper;
  int           m_left;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // GF(2^9) multiply as full carry-less product followed by reduction by x^9+x^4+1
  function automatic logic [8:0] gmul(input logic [8:0] a, input logic [8:0] b);
    logic [17:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) if (b[i]) p = p ^ (18'(a) << i);
    for (int i = 17; i >= 9; i--) if (p[i]) p = p ^ (18'h211 << (i - 9));
    return p[8:0];
  endfunction

  // A word is a codeword iff c(alpha^i) = 0 for i = 1..2t
  function automatic bit syn_zero(input logic [N-1:0] c);
    logic [8:0] a;
    logic [8:0] s;
    bit         ok;
    a  = 9'd1;
    ok = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      a = gmul(a, 9'd2);
      s = '0;
      for (int j = N - 1; j >= 0; j--) s = gmul(s, a) ^ {8'd0, c[j]};
      if (s != 9'd0) ok = 1'b0;
    end
    return ok;
  endfunction

  // Systematic parity: remainder of secret * x^72 divided by g(x), by textbook long division
  function automatic logic [PAR_BITS-1:0] model_parity(input logic [DATA_BITS-1:0] m);
    logic [N-1:0] v;
    v = {m, {PAR_BITS{1'b0}}};
    for (int i = N - 1; i >= PAR_BITS; i--)
      if (v[i]) v = v ^ (N'(BCH_GEN_POLY) << (i - PAR_BITS));
    return v[PAR_BITS-1:0];
  endfunction

  function automatic logic [N-1:0] model_code(input logic [DATA_BITS-1:0] m);
    return {m, model_parity(m)};
  endfunction

  function automatic logic [DATA_BITS-1:0] rnd_secret();
    logic [DATA_BITS-1:0] v;
    for (int i = 0; i < DATA_BITS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [N-1:0] rnd_resp();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] flips(input int w);
    logic [N-1:0] e;
    e = '0;
    while ($countones(e) < w) e[$urandom_range(N - 1, 0)] = 1'b1;
    return e;
  endfunction

  // Event-time model: a start seen while idle produces its result exactly 193 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_helper <= '0; m_code <= '0;
      m_next_code <= '0; m_next_helper <= '0; m_left <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_ready <= 1'b1;
        m_code <= m_next_code; m_helper <= m_next_helper;
      end
      m_left <= m_left - 1;
    end else if (bus.start === 1'b1) begin
      m_busy <= 1'b1; m_ready <= 1'b0; m_left <= DATA_BITS + 1;
      m_next_code   <= model_code(bus.secret);
      m_next_helper <= model_code(bus.secret) ^ bus.response;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("busy", bus.busy, m_busy);
      chk1("ready", bus.ready, m_ready);
      chkw("helper", bus.helper, m_helper);
      chkw("codeword", bus.codeword, m_code);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_encode(input logic [DATA_BITS-1:0] s, input logic [N-1:0] r, output int lat);
    bus.secret = s; bus.response = r; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  logic [DATA_BITS-1:0] a, b, s;
  logic [N-1:0]         r, rc;
  int                   lat;
  int                   wts[3] = '{0, 1, 8};

  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.secret = '0; bus.response = '0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; chk_en = 1'b1;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ready", bus.ready, 1'b0);
    chkw("rst_codeword", bus.codeword, '0);

    chk1("pin_syn_one", syn_zero(N'(1)), 1'b0);
    chk1("pin_gen_top", BCH_GEN_POLY[PAR_BITS], 1'b1);
    chk1("pin_gen_roots", syn_zero(N'(BCH_GEN_POLY)), 1'b1);

    r = rnd_resp();
    run_encode('0, r, lat);
    chk_int("zero_latency", lat, 193);
    chkw("zero_codeword", bus.codeword, '0);
    chkw("zero_helper", bus.helper, r);

    run_encode(DATA_BITS'(1), '0, lat);
    chk_int("lsb_latency", lat, 193);
    chkw("lsb_codeword", bus.codeword, {DATA_BITS'(1), BCH_GEN_POLY[PAR_BITS-1:0]});
    chkw("lsb_helper", bus.helper, {DATA_BITS'(1), BCH_GEN_POLY[PAR_BITS-1:0]});

    for (int p = 0; p < 3; p++) begin
      a = rnd_secret(); b = rnd_secret();
      run_encode(a, rnd_resp(), lat);
      chk1("lin_syn_a", syn_zero(bus.codeword), 1'b1);
      run_encode(b, rnd_resp(), lat);
      chk1("lin_syn_b", syn_zero(bus.codeword), 1'b1);
      run_encode(a ^ b, rnd_resp(), lat);
      chk_int("lin_latency", lat, 193);
      chkw("lin_parity", N'(bus.codeword[PAR_BITS-1:0]), N'(model_parity(a) ^ model_parity(b)));
      chk1("lin_syn_ab", syn_zero(bus.codeword), 1'b1);
    end

    s = rnd_secret(); r = rnd_resp();
    run_encode(s, r, lat);
    foreach (wts[k]) begin
      rc = bus.helper ^ (r ^ flips(wts[k]));
      chk1("rt_clean", syn_zero(rc), wts[k] == 0);
      if (wts[k] == 0) chkw("rt_codeword", rc, model_code(s));
    end

    a = rnd_secret(); b = rnd_secret(); r = rnd_resp();
    bus.secret = a; bus.response = r; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (49) tick();
    bus.secret = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 50;
    while (bus.ready !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    chk_int("busy_first_edge", lat, 193);
    chkw("busy_first_code", bus.codeword, model_code(a));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk1("busy_ready_drop", bus.ready, 1'b0);
    chk1("busy_rearm", bus.busy, 1'b1);
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    chk_int("busy_second_edge", lat + 194, 387);
    chkw("busy_second_code", bus.codeword, model_code(b));

    a = rnd_secret();
    bus.secret = a; bus.response = rnd_resp(); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (99) tick();
    #2; rst_n = 1'b0;
    #1;
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_ready", bus.ready, 1'b0);
    chkw("arst_helper", bus.helper, '0);
    chkw("arst_codeword", bus.codeword, '0);
    @(posedge clk);
    @(posedge clk);
    #1; rst_n = 1'b1;
    s = rnd_secret(); r = rnd_resp();
    run_encode(s, r, lat);
    chk_int("arst_latency", lat, 193);
    chkw("arst_new_code", bus.codeword, model_code(s));
    chkw("arst_new_helper", bus.helper, model_code(s) ^ r);

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
